// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the 5-stage core, including the ID/EX latch contents.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Field order matches the 6-bit control bus from decode, MSB first.
    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic dren;
        logic dwen;
        logic mem_to_reg;
        logic halt;
    } ctrl_t;

    typedef struct packed {
        word_t    pc4;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        aluop_t   aluop;
        ctrl_t    ctrl;
        logic     valid;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_latch_pipe_reg.sv
// Generic pipeline register: clear has priority over enable, otherwise holds.
module pipe_reg #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    input  T     d,
    input  T     clr_val,
    output T     q
);

    always_ff @(posedge clk) begin
        if (!n_rst)
            q <= '0;
        else if (clr)
            q <= clr_val;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with freeze, flush, load-use bubble, sticky halt and a
// saturating bubble/flush counter.
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             mem_busy,
    input  logic             flush,
    input  logic             lw_stall,
    input  word_t            pc4_in,
    input  word_t            rdat1_in,
    input  word_t            rdat2_in,
    input  word_t            imm_in,
    input  regbits_t         rs_in,
    input  regbits_t         rt_in,
    input  regbits_t         wsel_in,
    input  aluop_t           aluop_in,
    input  logic [5:0]       ctrl_in,
    output word_t            pc4_out_2,
    output word_t            rdat1_out_2,
    output word_t            rdat2_out_2,
    output word_t            imm_out_2,
    output regbits_t         rs_out_2,
    output regbits_t         rt_out_2,
    output regbits_t         wsel_out_2,
    output aluop_t           aluop_out_2,
    output logic [5:0]       ctrl_out_2,
    output logic             RegWrite_out_2,
    output logic             dREN_out_2,
    output logic             dWEN_out_2,
    output logic             halt_out_2,
    output logic             valid_out_2,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt
);

    idex_t captured;
    idex_t cur;
    logic  load_en;
    logic  load_bubble;
    logic  count_bubble;

    always_comb begin
        captured.pc4   = pc4_in;
        captured.rdat1 = rdat1_in;
        captured.rdat2 = rdat2_in;
        captured.imm   = imm_in;
        captured.rs    = rs_in;
        captured.rt    = rt_in;
        captured.wsel  = wsel_in;
        captured.aluop = aluop_in;
        captured.ctrl  = ctrl_t'(ctrl_in);
        captured.valid = 1'b1;
    end

    // A held halt freezes the stage like mem_busy, but a flush still squashes it.
    always_comb begin
        load_en      = 1'b0;
        load_bubble  = 1'b0;
        count_bubble = 1'b0;
        if (mem_busy) begin
            load_en = 1'b0;
        end else if (flush) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
        end else if (cur.ctrl.halt) begin
            load_en = 1'b0;
        end else if (lw_stall) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
        end else if (ihit) begin
            load_en = 1'b1;
        end else begin
            load_bubble = 1'b1;
        end
    end

    pipe_reg #(.T(idex_t)) u_idex_reg (
        .clk     (CLK),
        .n_rst   (nRST),
        .en      (load_en),
        .clr     (load_bubble),
        .d       (captured),
        .clr_val (IDEX_BUBBLE),
        .q       (cur)
    );

    always_ff @(posedge CLK) begin
        if (!nRST)
            bubble_cnt <= '0;
        else if (count_bubble && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

    assign stall_id       = lw_stall & ~flush & ~mem_busy;

    assign pc4_out_2      = cur.pc4;
    assign rdat1_out_2    = cur.rdat1;
    assign rdat2_out_2    = cur.rdat2;
    assign imm_out_2      = cur.imm;
    assign rs_out_2       = cur.rs;
    assign rt_out_2       = cur.rt;
    assign wsel_out_2     = cur.wsel;
    assign aluop_out_2    = cur.aluop;
    assign ctrl_out_2     = cur.ctrl;
    assign RegWrite_out_2 = cur.ctrl.reg_write;
    assign dREN_out_2     = cur.ctrl.dren;
    assign dWEN_out_2     = cur.ctrl.dwen;
    assign halt_out_2     = cur.ctrl.halt;
    assign valid_out_2    = cur.valid;

endmodule

// File: tb/tb_id_ex_latch.sv
// Scoreboard bench for id_ex_latch: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_id_ex_latch;
    import cpu_types_pkg::*;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        nrst;
        logic        ihit;
        logic        mem_busy;
        logic        flush;
        logic        lw_stall;
        logic [31:0] pc4;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wsel;
        logic [3:0]  aluop;
        logic [5:0]  ctrl;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wsel;
        logic [3:0]  aluop;
        logic [5:0]  ctrl;
        logic        valid;
        logic [7:0]  cnt;
    } obs_t;

    typedef struct packed {
        obs_t regs;
        logic stall;
    } exp_t;

    logic             CLK;
    logic             nRST;
    logic             ihit, mem_busy, flush, lw_stall;
    word_t            pc4_in, rdat1_in, rdat2_in, imm_in;
    regbits_t         rs_in, rt_in, wsel_in;
    aluop_t           aluop_in;
    logic [5:0]       ctrl_in;
    word_t            pc4_out_2, rdat1_out_2, rdat2_out_2, imm_out_2;
    regbits_t         rs_out_2, rt_out_2, wsel_out_2;
    aluop_t           aluop_out_2;
    logic [5:0]       ctrl_out_2;
    logic             RegWrite_out_2, dREN_out_2, dWEN_out_2, halt_out_2;
    logic             valid_out_2, stall_id;
    logic [CNT_W-1:0] bubble_cnt;

    exp_t sb[$];
    obs_t model;
    bit   primed;
    int   n_checks;
    int   n_pass;

    id_ex_latch #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_busy(mem_busy), .flush(flush),
        .lw_stall(lw_stall), .pc4_in(pc4_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in),
        .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .wsel_in(wsel_in),
        .aluop_in(aluop_in), .ctrl_in(ctrl_in), .pc4_out_2(pc4_out_2),
        .rdat1_out_2(rdat1_out_2), .rdat2_out_2(rdat2_out_2), .imm_out_2(imm_out_2),
        .rs_out_2(rs_out_2), .rt_out_2(rt_out_2), .wsel_out_2(wsel_out_2),
        .aluop_out_2(aluop_out_2), .ctrl_out_2(ctrl_out_2),
        .RegWrite_out_2(RegWrite_out_2), .dREN_out_2(dREN_out_2),
        .dWEN_out_2(dWEN_out_2), .halt_out_2(halt_out_2), .valid_out_2(valid_out_2),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [191:0] actual,
                                input logic [191:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic obs_t bubble_of(input obs_t s, input bit counts);
        obs_t r;
        r = '0;
        r.cnt = s.cnt;
        if (counts && (int'(s.cnt) < CNT_MAX))
            r.cnt = s.cnt + 8'd1;
        return r;
    endfunction

    // Priority order of the stage, written directly from the behavioural rules.
    function automatic obs_t model_next(input obs_t s, input stim_t x);
        obs_t r;
        r = s;
        if (!x.nrst)
            r = '0;
        else if (x.mem_busy)
            r = s;
        else if (x.flush)
            r = bubble_of(s, 1'b1);
        else if (s.ctrl[0])
            r = s;
        else if (x.lw_stall)
            r = bubble_of(s, 1'b1);
        else if (x.ihit) begin
            r.pc4 = x.pc4;   r.rdat1 = x.rdat1; r.rdat2 = x.rdat2; r.imm = x.imm;
            r.rs  = x.rs;    r.rt    = x.rt;    r.wsel  = x.wsel;  r.aluop = x.aluop;
            r.ctrl = x.ctrl; r.valid = 1'b1;
        end else
            r = bubble_of(s, 1'b0);
        return r;
    endfunction

    task automatic apply_stimulus(input stim_t x);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = x.nrst;  ihit = x.ihit;  mem_busy = x.mem_busy;
        flush = x.flush; lw_stall = x.lw_stall;
        pc4_in = x.pc4; rdat1_in = x.rdat1; rdat2_in = x.rdat2; imm_in = x.imm;
        rs_in = x.rs;   rt_in = x.rt;   wsel_in = x.wsel;
        aluop_in = aluop_t'(x.aluop);   ctrl_in = x.ctrl;
        if (primed) begin
            e.regs  = model;
            e.stall = x.lw_stall && !x.flush && !x.mem_busy;
            sb.push_back(e);
        end
        model  = model_next(model, x);
        primed = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        stim_t x;
        x.nrst     = ($urandom_range(0, 99) >= 3);
        x.ihit     = ($urandom_range(0, 99) < 80);
        x.mem_busy = ($urandom_range(0, 99) < 15);
        x.flush    = ($urandom_range(0, 99) < 10);
        x.lw_stall = ($urandom_range(0, 99) < 15);
        x.pc4      = $urandom;
        x.rdat1    = $urandom;
        x.rdat2    = $urandom;
        x.imm      = $urandom;
        x.rs       = 5'($urandom);
        x.rt       = 5'($urandom);
        x.wsel     = 5'($urandom);
        x.aluop    = 4'($urandom);
        x.ctrl     = {5'($urandom), ($urandom_range(0, 99) < 5)};
        return x;
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        obs_t act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {pc4_out_2, rdat1_out_2, rdat2_out_2, imm_out_2, rs_out_2, rt_out_2,
                   wsel_out_2, 4'(aluop_out_2), ctrl_out_2, valid_out_2, bubble_cnt};
            check_output("regs", 192'(act), 192'(e.regs));
            check_output("stall_id", 192'(stall_id), 192'(e.stall));
            check_output("breakout", 192'({RegWrite_out_2, dREN_out_2, dWEN_out_2, halt_out_2}),
                         192'({e.regs.ctrl[4], e.regs.ctrl[3], e.regs.ctrl[2], e.regs.ctrl[0]}));
        end
    end

    initial begin
        stim_t x;
        int    wait_cycles;
        n_checks = 0;
        n_pass   = 0;
        primed   = 1'b0;
        model    = '0;
        nRST = 1'b0; ihit = 1'b0; mem_busy = 1'b0; flush = 1'b0; lw_stall = 1'b0;
        pc4_in = '0; rdat1_in = '0; rdat2_in = '0; imm_in = '0;
        rs_in = '0; rt_in = '0; wsel_in = '0; aluop_in = ALU_SLL; ctrl_in = '0;

        // Reset held for two cycles under random inputs.
        for (int i = 0; i < 2; i++) begin
            x = rand_stim();
            x.nrst = 1'b0;
            apply_stimulus(x);
        end

        // Plain capture of a RegWrite instruction.
        x = rand_stim();
        x.nrst = 1'b1; x.ihit = 1'b1; x.mem_busy = 1'b0; x.flush = 1'b0; x.lw_stall = 1'b0;
        x.rs = 5'd3; x.rt = 5'd4; x.wsel = 5'd5; x.ctrl = 6'b010000;
        apply_stimulus(x);
        check_output("reset_valid", 192'(valid_out_2), 192'(0));
        check_output("reset_cnt", 192'(bubble_cnt), 192'(0));

        // Load-use: bubble while decode re-presents, then capture the same instruction.
        x.rs = 5'd7; x.rt = 5'd3; x.wsel = 5'd9; x.ctrl = 6'b110000; x.lw_stall = 1'b1;
        apply_stimulus(x);
        check_output("capture_rs_rt_wsel", 192'({rs_out_2, rt_out_2, wsel_out_2}),
                     192'({5'd3, 5'd4, 5'd5}));
        x.lw_stall = 1'b0;
        apply_stimulus(x);
        check_output("loaduse_cnt", 192'(bubble_cnt), 192'(1));

        // Memory freeze overrides flush and load-use for three cycles.
        for (int i = 0; i < 3; i++) begin
            x.mem_busy = 1'b1; x.flush = 1'b1; x.lw_stall = 1'b1; x.pc4 = $urandom;
            apply_stimulus(x);
        end

        // Flush and load-use together: one bubble, one count.
        x.mem_busy = 1'b0; x.flush = 1'b1; x.lw_stall = 1'b1;
        apply_stimulus(x);

        // Sticky halt: captured halt blocks captures and load-use bubbles until a flush.
        x.flush = 1'b0; x.lw_stall = 1'b0; x.ctrl = 6'b000001;
        apply_stimulus(x);
        for (int i = 0; i < 4; i++) begin
            x = rand_stim();
            x.nrst = 1'b1; x.mem_busy = 1'b0; x.flush = 1'b0; x.ctrl = 6'b010000;
            apply_stimulus(x);
        end
        check_output("halt_sticky", 192'(halt_out_2), 192'(1));
        x.flush = 1'b1;
        apply_stimulus(x);
        x.flush = 1'b0;
        apply_stimulus(x);
        check_output("halt_cleared", 192'(halt_out_2), 192'(0));

        for (int i = 0; i < 400; i++)
            apply_stimulus(rand_stim());

        // Drive the counter into saturation and past it.
        for (int i = 0; i < CNT_MAX + 40; i++) begin
            x = rand_stim();
            x.nrst = 1'b1; x.mem_busy = 1'b0; x.flush = 1'b1;
            apply_stimulus(x);
        end
        x.flush = 1'b0;
        apply_stimulus(x);
        check_output("cnt_saturated", 192'(bubble_cnt), 192'(CNT_MAX));

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
